// File: rtl/sec_cnt_pkg.sv
// rtl/sec_cnt_pkg.sv - shared FSM type and BCD limits for the elapsed-time counter
package sec_cnt_pkg;

    localparam int DIGIT_W  = 4;
    localparam int ONES_MAX = 9;
    localparam int TENS_MAX = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_FULL = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_up.sv
// rtl/bcd_digit_up.sv - one BCD up-counting digit that wraps to 0 past MAX and flags a carry
module bcd_digit_up
    import sec_cnt_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CLR,
    input  logic               INC,
    output logic [DIGIT_W-1:0] VAL,
    output logic               CARRY
);

    logic [DIGIT_W-1:0] r_val;

    assign CARRY = INC && (r_val == DIGIT_W'(MAX));
    assign VAL   = r_val;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_val <= '0;
        end else if (CLR) begin
            r_val <= '0;
        end else if (INC) begin
            r_val <= CARRY ? '0 : r_val + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/sec_cnt_up.sv
// rtl/sec_cnt_up.sv - stopwatch: prescaled one-second tick into BCD seconds and a minutes digit
module sec_cnt_up
    import sec_cnt_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int MAX_MIN = 9
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic               CLR,
    output logic [DIGIT_W-1:0] SEC_ONES,
    output logic [DIGIT_W-1:0] SEC_TENS,
    output logic [DIGIT_W-1:0] MIN,
    output logic               EN_SEC,
    output logic               OVF,
    output logic               RUNNING
);

    localparam int PRE_W = $clog2(CLK_DIV);

    state_t             r_state;
    state_t             w_next_state;
    logic [PRE_W-1:0]   r_pre;
    logic               r_en_sec;
    logic               r_ovf;
    logic               r_running;
    logic               w_running_d;
    logic               w_cnt_en;
    logic               w_tick;
    logic               w_at_max;
    logic               w_sat_tick;
    logic               w_inc;
    logic               w_nonzero;
    logic               w_ones_carry;
    logic               w_tens_carry;
    logic               w_min_carry;
    logic [DIGIT_W-1:0] w_ones;
    logic [DIGIT_W-1:0] w_tens;
    logic [DIGIT_W-1:0] w_min;

    assign w_cnt_en   = EN && !CLR && (r_state != ST_FULL);
    assign w_tick     = w_cnt_en && (r_pre == PRE_W'(CLK_DIV - 1));
    assign w_at_max   = (w_min == DIGIT_W'(MAX_MIN)) && (w_tens == DIGIT_W'(TENS_MAX))
                        && (w_ones == DIGIT_W'(ONES_MAX));
    assign w_sat_tick = w_tick && w_at_max;
    assign w_inc      = w_tick && !w_at_max;
    assign w_nonzero  = (w_ones != '0) || (w_tens != '0) || (w_min != '0) || (r_pre != '0);

    // Prescaler holds while paused so a resumed second keeps its elapsed fraction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pre <= '0;
        end else if (CLR) begin
            r_pre <= '0;
        end else if (w_cnt_en) begin
            r_pre <= (r_pre == PRE_W'(CLK_DIV - 1)) ? '0 : r_pre + PRE_W'(1);
        end
    end

    bcd_digit_up #(.MAX(ONES_MAX)) u_ones (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .INC   (w_inc),
        .VAL   (w_ones),
        .CARRY (w_ones_carry)
    );

    bcd_digit_up #(.MAX(TENS_MAX)) u_tens (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .INC   (w_ones_carry),
        .VAL   (w_tens),
        .CARRY (w_tens_carry)
    );

    bcd_digit_up #(.MAX(MAX_MIN)) u_min (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .INC   (w_tens_carry),
        .VAL   (w_min),
        .CARRY (w_min_carry)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (CLR) begin
            w_next_state = ST_IDLE;
        end else if (r_state == ST_FULL) begin
            w_next_state = ST_FULL;
        end else if (w_sat_tick) begin
            w_next_state = ST_FULL;
        end else if (EN) begin
            w_next_state = ST_RUN;
        end else if (w_nonzero) begin
            w_next_state = ST_HOLD;
        end else begin
            w_next_state = ST_IDLE;
        end
    end

    assign w_running_d = (w_next_state == ST_RUN);

    // A minutes carry can only mean a wrap past MAX_MIN, so it is folded into overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_en_sec  <= 1'b0;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_en_sec  <= w_inc;
            r_running <= w_running_d;
            if (CLR) begin
                r_ovf <= 1'b0;
            end else if (w_sat_tick || w_min_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign SEC_ONES = w_ones;
    assign SEC_TENS = w_tens;
    assign MIN      = w_min;
    assign EN_SEC   = r_en_sec;
    assign OVF      = r_ovf;
    assign RUNNING  = r_running;

endmodule
